// File: rtl/noise_chk.sv
// Receive-side checker for the 12-bit PRBS b[n] = b[n-1]^b[n-4]^b[n-5]^b[n-12].
// Define NOISE_CHK_BITCNT_EN to add the bit_cnt port and its valid-bit counter.
module noise_chk #(
    parameter int LOCK_CNT = 24,
    parameter int LOSS_WIN = 64,
    parameter int LOSS_THR = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_en,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt
`ifdef NOISE_CHK_BITCNT_EN
    ,
    output logic [CNT_W-1:0] bit_cnt
`endif
);

    localparam int RUN_W  = 8;
    localparam int WIN_W  = $clog2(LOSS_WIN);
    localparam int WERR_W = $clog2(LOSS_WIN + 1);

    localparam logic [11:0]       TAP_MASK  = 12'b1000_0001_1001;
    localparam logic [3:0]        FILL_FULL = 4'd12;
    localparam logic [RUN_W-1:0]  RUN_LOCK  = RUN_W'(LOCK_CNT);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(LOSS_WIN - 1);
    localparam logic [WERR_W-1:0] WERR_THR  = WERR_W'(LOSS_THR);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [11:0]       sreg_q, sreg_d;
    logic [3:0]        fill_q, fill_d;
    logic [RUN_W-1:0]  run_q, run_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0] win_err_q, win_err_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              err_pulse_q, err_pulse_d;

    logic [11:0]       tapped;
    logic              pred;
    logic              mismatch;
    logic [RUN_W-1:0]  run_nxt;
    logic [WERR_W-1:0] win_err_nxt;

    // Prediction is the XOR of the tapped history bits.
    generate
        for (genvar gi = 0; gi < 12; gi++) begin : g_tap
            assign tapped[gi] = sreg_q[gi] & TAP_MASK[gi];
        end
    endgenerate

    assign pred        = ^tapped;
    assign mismatch    = (din != pred);
    assign win_err_nxt = win_err_q + WERR_W'(mismatch);

    always_comb begin
        run_nxt = '0;
        if ((sreg_q != '0) && !mismatch) begin
            run_nxt = run_q + RUN_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        sreg_d      = sreg_q;
        fill_d      = fill_q;
        run_d       = run_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        err_cnt_d   = err_cnt_q;
        err_pulse_d = 1'b0;

        if (din_en) begin
            case (state_q)
                ST_HUNT: begin
                    sreg_d = {sreg_q[10:0], din};
                    if (fill_q != FILL_FULL) begin
                        fill_d = fill_q + 4'd1;
                    end else if (run_nxt == RUN_LOCK) begin
                        state_d   = ST_LOCKED;
                        run_d     = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        run_d = run_nxt;
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: feed back our own prediction so a line error hits once.
                    sreg_d = {sreg_q[10:0], pred};
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        if (err_cnt_q != CNT_MAX) begin
                            err_cnt_d = err_cnt_q + CNT_W'(1);
                        end
                    end
                    if (win_err_nxt >= WERR_THR) begin
                        state_d   = ST_HUNT;
                        fill_d    = '0;
                        run_d     = '0;
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else if (win_cnt_q == WIN_LAST) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_W'(1);
                        win_err_d = win_err_nxt;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end

        if (clr) begin
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            sreg_q      <= '0;
            fill_q      <= '0;
            run_q       <= '0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
            err_cnt_q   <= '0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            fill_q      <= fill_d;
            run_q       <= run_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
            err_cnt_q   <= err_cnt_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign locked    = (state_q == ST_LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;

`ifdef NOISE_CHK_BITCNT_EN
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        if (din_en && (state_q == ST_LOCKED) && (bit_cnt_q != CNT_MAX)) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
        if (clr) begin
            bit_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign bit_cnt = bit_cnt_q;
`endif

endmodule

// File: tb/tb_noise_chk.sv
// Bench for noise_chk: vector table, hand-written corner sequences and a randomized
// run, all compared against a queue-based model of the checker rules.
`timescale 1ns/1ps
module tb_noise_chk;

    localparam int LOCK_CNT = 24;
    localparam int LOSS_WIN = 64;
    localparam int LOSS_THR = 8;
    localparam int CNT_W    = 4;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;
    localparam int TBL_N    = 48;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic din = 1'b0;
    logic din_en = 1'b0;
    logic clr = 1'b0;
    logic locked;
    logic err_pulse;
    logic [CNT_W-1:0] err_cnt;
`ifdef NOISE_CHK_BITCNT_EN
    logic [CNT_W-1:0] bit_cnt;
`endif

    noise_chk #(
        .LOCK_CNT(LOCK_CNT),
        .LOSS_WIN(LOSS_WIN),
        .LOSS_THR(LOSS_THR),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_en   (din_en),
        .clr      (clr),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_cnt  (err_cnt)
`ifdef NOISE_CHK_BITCNT_EN
        ,
        .bit_cnt  (bit_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit din;
        bit en;
        bit clr;
        bit exp_locked;
        bit exp_pulse;
    } vec_t;

    vec_t tbl [TBL_N];

    int checks = 0;
    int failures = 0;
    int n_pulses = 0;
    bit seen_locked = 0;

    // Transmitter-side generator
    logic [11:0] g = 12'h001;

    // Reference model state: history of the last 12 bits (oldest first)
    bit m_hist[$];
    bit m_locked;
    int m_run, m_win, m_werr, m_err, m_bits;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic gen_next(output bit b);
        b = g[0] ^ g[3] ^ g[4] ^ g[11];
        g = {g[10:0], b};
    endtask

    task automatic model_reset();
        m_hist.delete();
        m_locked = 0;
        m_run = 0;
        m_win = 0;
        m_werr = 0;
        m_err = 0;
        m_bits = 0;
    endtask

    function automatic bit model_pred();
        return m_hist[11] ^ m_hist[8] ^ m_hist[7] ^ m_hist[0];
    endfunction

    task automatic model_step(input bit d, input bit en, input bit c, output bit pe);
        bit p;
        bit nz;
        pe = 0;
        if (en) begin
            if (!m_locked) begin
                if (m_hist.size() == 12) begin
                    nz = 0;
                    foreach (m_hist[k]) nz = nz | m_hist[k];
                    p = model_pred();
                    m_run = (nz && (d == p)) ? m_run + 1 : 0;
                    void'(m_hist.pop_front());
                end
                m_hist.push_back(d);
                if (m_run == LOCK_CNT) begin
                    m_locked = 1;
                    m_run = 0;
                    m_win = 0;
                    m_werr = 0;
                end
            end else begin
                p = model_pred();
                void'(m_hist.pop_front());
                m_hist.push_back(p);
                if (m_bits < CNT_MAX) m_bits++;
                if (d != p) begin
                    pe = 1;
                    m_werr++;
                    if (m_err < CNT_MAX) m_err++;
                end
                m_win++;
                if (m_werr >= LOSS_THR) begin
                    m_locked = 0;
                    m_hist.delete();
                    m_run = 0;
                    m_win = 0;
                    m_werr = 0;
                end else if (m_win == LOSS_WIN) begin
                    m_win = 0;
                    m_werr = 0;
                end
            end
        end
        if (c) begin
            m_err = 0;
            m_bits = 0;
        end
    endtask

    task automatic step(input bit d, input bit en, input bit c);
        bit pe;
        din = d;
        din_en = en;
        clr = c;
        @(posedge clk);
        #1;
        model_step(d, en, c, pe);
        if (err_pulse) n_pulses++;
        if (locked) seen_locked = 1;
        check("model", {locked, err_pulse, err_cnt}, {m_locked, pe, m_err[CNT_W-1:0]});
`ifdef NOISE_CHK_BITCNT_EN
        check("bitcnt", bit_cnt, m_bits[CNT_W-1:0]);
`endif
        din_en = 0;
        clr = 0;
    endtask

    task automatic send(input bit flip, input bit c);
        bit b;
        gen_next(b);
        step(b ^ flip, 1'b1, c);
    endtask

    task automatic gap_send(input bit flip);
        send(flip, 1'b0);
        step(1'($urandom_range(1)), 1'b0, 1'b0);
        step(1'($urandom_range(1)), 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 0;
        din_en = 0;
        clr = 0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1;
    endtask

    task automatic align_window();
        int n;
        n = 0;
        while (m_win != 0 && n < LOSS_WIN) begin
            send(1'b0, 1'b0);
            n++;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int v;
        int n;
        int rate;
        bit b;
        bit en;
        bit c;
        bit flip;

        // Vector table: generator stream with a gap every 5th cycle; lock after 36 valid bits
        v = 0;
        for (int i = 0; i < TBL_N; i++) begin
            tbl[i].en  = (i % 5 != 4);
            tbl[i].clr = (i == 20);
            if (tbl[i].en) begin
                gen_next(b);
                v++;
            end else begin
                b = 1'($urandom_range(1));
            end
            tbl[i].din        = b;
            tbl[i].exp_locked = (v >= 12 + LOCK_CNT);
            tbl[i].exp_pulse  = 0;
        end

        // Reset state
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", locked, 0);
        check("rst_pulse", err_pulse, 0);
        check("rst_cnt", err_cnt, 0);
        rst_n = 1;
        $display("reset: checks=%0d failures=%0d", checks, failures);

        for (int i = 0; i < TBL_N; i++) begin
            step(tbl[i].din, tbl[i].en, tbl[i].clr);
            check($sformatf("tbl%0d", i), {locked, err_pulse}, {tbl[i].exp_locked, tbl[i].exp_pulse});
        end
        $display("table: checks=%0d failures=%0d", checks, failures);

        // Long clean run
        n_pulses = 0;
        for (int i = 0; i < 10000; i++) send(1'b0, 1'b0);
        check("clean_cnt", err_cnt, 0);
        check("clean_pulses", n_pulses, 0);
        check("clean_locked", locked, 1);
        $display("clean run: checks=%0d failures=%0d", checks, failures);

        // Single line error
        n_pulses = 0;
        send(1'b1, 1'b0);
        for (int i = 0; i < 200; i++) send(1'b0, 1'b0);
        check("single_pulses", n_pulses, 1);
        check("single_cnt", err_cnt, 1);
        check("single_locked", locked, 1);
        $display("single error: checks=%0d failures=%0d", checks, failures);

        // Eight errors in one window -> loss, then relock after 12+24 bits
        send(1'b0, 1'b1);
        align_window();
        for (int k = 0; k < 8; k++) begin
            send(1'b1, 1'b0);
            if (k == 6) check("win8_still_locked", locked, 1);
            if (k == 7) begin
                check("win8_lost", locked, 0);
                check("win8_cnt", err_cnt, 8);
            end else begin
                repeat (3) send(1'b0, 1'b0);
            end
        end
        n = 0;
        while (!locked && n < 100) begin
            send(1'b0, 1'b0);
            n++;
        end
        check("relock_bits", n, 12 + LOCK_CNT);
        $display("window loss: checks=%0d failures=%0d", checks, failures);

        // Seven errors in each of two consecutive windows -> stays locked
        send(1'b0, 1'b1);
        align_window();
        for (int k = 0; k < 7; k++) begin
            send(1'b1, 1'b0);
            repeat (3) send(1'b0, 1'b0);
        end
        align_window();
        for (int k = 0; k < 7; k++) begin
            send(1'b1, 1'b0);
            repeat (3) send(1'b0, 1'b0);
        end
        for (int i = 0; i < 70; i++) send(1'b0, 1'b0);
        check("two_win_locked", locked, 1);
        check("two_win_cnt", err_cnt, 14);
        $display("two windows: checks=%0d failures=%0d", checks, failures);

        // All-zero input never locks
        do_reset();
        seen_locked = 0;
        for (int i = 0; i < 1000; i++) step(1'b0, 1'b1, 1'b0);
        check("zeros_never_locked", seen_locked, 0);
        $display("all zeros: checks=%0d failures=%0d", checks, failures);

        // din_en every third cycle
        do_reset();
        for (int k = 1; k <= 12 + LOCK_CNT; k++) begin
            gap_send(1'b0);
            if (k == 11 + LOCK_CNT) check("gap_not_yet", locked, 0);
        end
        check("gap_locked", locked, 1);
        n_pulses = 0;
        for (int k = 0; k < 30; k++) gap_send(1'b0);
        gap_send(1'b1);
        for (int k = 0; k < 30; k++) gap_send(1'b0);
        check("gap_pulses", n_pulses, 1);
        check("gap_cnt", err_cnt, 1);
        check("gap_still_locked", locked, 1);
        $display("gapped enable: checks=%0d failures=%0d", checks, failures);

        // Counter saturation, clear priority, async reset while locked
        do_reset();
        for (int i = 0; i < 40; i++) send(1'b0, 1'b0);
        check("sat_locked", locked, 1);
        for (int k = 0; k < 20; k++) begin
            send(1'b1, 1'b0);
            repeat (99) send(1'b0, 1'b0);
        end
        check("sat_cnt", err_cnt, CNT_MAX);
        send(1'b1, 1'b1);
        check("clr_wins_cnt", err_cnt, 0);
        check("clr_wins_pulse", err_pulse, 1);
        send(1'b1, 1'b0);
        check("post_clr_cnt", err_cnt, 1);
        #2;
        rst_n = 0;
        #1;
        check("async_locked", locked, 0);
        check("async_cnt", err_cnt, 0);
        check("async_pulse", err_pulse, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
        $display("saturation/async reset: checks=%0d failures=%0d", checks, failures);

        // Randomized traffic: clean, sparse errors, then dense errors
        for (int i = 0; i < 6000; i++) begin
            rate = (i < 2000) ? 0 : ((i < 4000) ? 150 : 7);
            en   = ($urandom_range(3) != 0);
            c    = ($urandom_range(399) == 0);
            if (en) begin
                gen_next(b);
                flip = (rate != 0) && ($urandom_range(rate - 1) == 0);
                step(b ^ flip, 1'b1, c);
            end else begin
                step(1'($urandom_range(1)), 1'b0, c);
            end
        end
        $display("random: checks=%0d failures=%0d", checks, failures);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
